hex_glyph_renderer: RTL and testbench
=====================================

HEX_GLYPH_RENDERER -- requirements
Module: hex_glyph_renderer

Interface
REQ-001 Parameter DIGITS, default 2: number of 4-bit hex digits rendered; must be at least 1.
REQ-002 Parameter SCALE, default 1: integer pixel replication factor per glyph cell; must be at least 1.
REQ-003 Parameter GAP, default 1: blank glyph-columns between digits, in unscaled cells.
REQ-004 Parameter FB_WIDTH, default 30, and FB_HEIGHT, default 40: framebuffer dimensions in pixels.
REQ-005 Parameter ADDR_W, default 11: framebuffer address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT.
REQ-006 Parameter COORD_W, default 8: width of the xpos and ypos inputs.
REQ-007 clock  in  1  single clock; all state is updated on its rising edge.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  render request; sampled only in IDLE.
REQ-010 value  in  4*DIGITS  hex value; the most significant nibble is the leftmost digit.
REQ-011 xpos, ypos  in  COORD_W each  top-left pixel of digit 0.
REQ-012 transparent  in  1  when 1, glyph-off pixels are not written.
REQ-013 pix_valid  out  1  a pixel write is offered.
REQ-014 pix_ready  in  1  the framebuffer accepts the write.
REQ-015 pix_addr  out  ADDR_W  write address, equal to y*FB_WIDTH + x.
REQ-016 pix_data  out  1  pixel value: 1 = on.
REQ-017 busy  out  1  high from the cycle after start is accepted until done.
REQ-018 done  out  1  one-cycle completion pulse.

Function
REQ-019 Glyphs are 3 wide by 5 tall, 15 bits each. Bit 14 is top-left. Row r occupies bits 14-3r down to 12-3r, with the left column first.
REQ-020 Glyph table (hex): 0=7B6F, 1=1249, 2=73E7, 3=73CF, 4=5BC9, 5=79CF, 6=79EF, 7=7249, 8=7BEF, 9=7BC9, A=7BED, B=49EF, C=7927, D=13EF, E=79A7, F=79E4.
REQ-021 The states are IDLE, CALC, EMIT and DONE.
REQ-022 IDLE with start=1: latch value, xpos, ypos and transparent, then go to CALC. Inputs that change afterwards have no effect on the render in progress.
REQ-023 Traversal order, outermost loop first: digit d (0 = MS nibble), glyph row, sub-row (0..SCALE-1), glyph column, sub-column (0..SCALE-1).
REQ-024 Pixel coordinates: x = xpos + d*(3+GAP)*SCALE + col*SCALE + subcol; y = ypos + row*SCALE + subrow.
REQ-025 Coordinates are computed at a width that cannot wrap.
REQ-026 CALC, pixel invisible (x >= FB_WIDTH, or y >= FB_HEIGHT, or transparent=1 with cell bit 0): advance to the next pixel in one cycle with pix_valid=0.
REQ-027 CALC, pixel visible: go to EMIT.
REQ-028 EMIT: pix_valid=1, and pix_addr and pix_data stay stable until pix_valid and pix_ready are both 1.
REQ-029 EMIT, transfer completes: advance to the next pixel and return to CALC. After the last pixel, go to DONE instead.
REQ-030 The last pixel is determined by traversal position, not by visibility. A fully clipped render still ends in DONE.
REQ-031 DONE: done=1 and busy=0 for one cycle, then return to IDLE. A start in this cycle is ignored.
REQ-032 start while busy is ignored.
REQ-033 Latency: start accepted at cycle N gives CALC at N+1, and the first possible pix_valid at N+2. Each visible pixel takes at least 2 cycles.
REQ-034 The traversal covers DIGITS*15*SCALE*SCALE pixel positions. Gap columns are never written.

Reset
REQ-035 Asserting reset_n low immediately forces IDLE and sets pix_valid, busy, done, pix_addr and pix_data to 0, including during a render.
REQ-036 A render interrupted by reset is abandoned. No done pulse is produced and no further writes are issued after reset is released.

Verification
REQ-037 Defaults, value=0x1A, xpos=0, ypos=0, transparent=0, pix_ready=1 -> 30 writes.
- Writes 1-3 are (addr 0, data 0), (addr 1, data 0), (addr 2, data 1).
- The first write of digit 1 is to addr 4, data 1.
- A single done pulse follows the final write.
REQ-038 Same stimulus, with pix_ready low for 5 cycles on every third write -> the identical write sequence. Addr and data are held while stalled, with no duplicate writes.
REQ-039 xpos=28, ypos=0, value=0x88 -> only columns 28 and 29 of digit 0 are written, 10 writes total; digit 1 is fully skipped; done still pulses.
REQ-040 transparent=1, value=0x11 -> exactly 10 writes, all data 1, at addresses 2, 32, 62, 92, 122, 6, 36, 66, 96 and 126.
REQ-041 SCALE=2, value=0x80 -> 120 traversal positions. The first four writes are addresses 0, 1, 2 and 3, all with data 1.
REQ-042 Reset asserted during the 7th write -> pix_valid drops asynchronously and the block returns to IDLE. A new start produces the full sequence from the first pixel.

Source files
------------

// File: rtl/hex_glyph_renderer_if.sv
// rtl/hex_glyph_renderer_if.sv - pixel write channel between the glyph renderer and a framebuffer
interface hex_glyph_renderer_if #(
    parameter int ADDR_W = 11
);
    logic              pix_valid;
    logic              pix_ready;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_data;

    modport master (
        output pix_valid,
        output pix_addr,
        output pix_data,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_addr,
        input  pix_data,
        output pix_ready
    );
endinterface

// File: rtl/hex_glyph_renderer.sv
// rtl/hex_glyph_renderer.sv - draws a hex value as scaled 3x5 glyphs, one framebuffer pixel write at a time
module hex_glyph_renderer #(
    parameter int DIGITS    = 2,
    parameter int SCALE     = 1,
    parameter int GAP       = 1,
    parameter int FB_WIDTH  = 30,
    parameter int FB_HEIGHT = 40,
    parameter int ADDR_W    = 11,
    parameter int COORD_W   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [COORD_W-1:0]    xpos,
    input  logic [COORD_W-1:0]    ypos,
    input  logic                  transparent,
    hex_glyph_renderer_if.master  pix,
    output logic                  busy,
    output logic                  done
);
    localparam int DIGIT_STEP = (3 + GAP) * SCALE;
    localparam int X_SPAN     = DIGITS * DIGIT_STEP;
    localparam int Y_SPAN     = 5 * SCALE;
    // One spare bit beyond the largest reachable coordinate so the sums never wrap.
    localparam int X_W        = $clog2((1 << COORD_W) + X_SPAN) + 1;
    localparam int Y_W        = $clog2((1 << COORD_W) + Y_SPAN) + 1;
    localparam int D_W        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int S_W        = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [D_W-1:0] DIGIT_LAST = D_W'(DIGITS - 1);
    localparam logic [S_W-1:0] SUB_LAST   = S_W'(SCALE - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          state;
    logic [4*DIGITS-1:0] value_q;
    logic [COORD_W-1:0]  xpos_q;
    logic [COORD_W-1:0]  ypos_q;
    logic                transparent_q;

    logic [D_W-1:0]      digit;
    logic [2:0]          row;
    logic [S_W-1:0]      sub_row;
    logic [1:0]          col;
    logic [S_W-1:0]      sub_col;

    logic [D_W-1:0]      n_digit;
    logic [2:0]          n_row;
    logic [S_W-1:0]      n_sub_row;
    logic [1:0]          n_col;
    logic [S_W-1:0]      n_sub_col;

    logic [3:0]          nibble;
    logic [14:0]         glyph;
    logic [2:0]          row_bits;
    logic                cell_on;
    logic [X_W-1:0]      px;
    logic [Y_W-1:0]      py;
    logic                visible;
    logic                last_pos;
    logic [ADDR_W-1:0]   addr_calc;

    function automatic logic [14:0] glyph_rom(input logic [3:0] n);
        case (n)
            4'h0:    glyph_rom = 15'h7B6F;
            4'h1:    glyph_rom = 15'h1249;
            4'h2:    glyph_rom = 15'h73E7;
            4'h3:    glyph_rom = 15'h73CF;
            4'h4:    glyph_rom = 15'h5BC9;
            4'h5:    glyph_rom = 15'h79CF;
            4'h6:    glyph_rom = 15'h79EF;
            4'h7:    glyph_rom = 15'h7249;
            4'h8:    glyph_rom = 15'h7BEF;
            4'h9:    glyph_rom = 15'h7BC9;
            4'hA:    glyph_rom = 15'h7BED;
            4'hB:    glyph_rom = 15'h49EF;
            4'hC:    glyph_rom = 15'h7927;
            4'hD:    glyph_rom = 15'h13EF;
            4'hE:    glyph_rom = 15'h79A7;
            default: glyph_rom = 15'h79E4;
        endcase
    endfunction

    // Digit 0 is the most significant nibble, so it sits at the top of value_q.
    always_comb begin
        nibble   = 4'(value_q >> (4 * (DIGITS - 1 - int'(digit))));
        glyph    = glyph_rom(nibble);
        row_bits = 3'(glyph >> (12 - 3 * int'(row)));
        case (col)
            2'd0:    cell_on = row_bits[2];
            2'd1:    cell_on = row_bits[1];
            default: cell_on = row_bits[0];
        endcase
    end

    always_comb begin
        px = X_W'(xpos_q) + X_W'(DIGIT_STEP * int'(digit)) + X_W'(SCALE * int'(col)) + X_W'(sub_col);
        py = Y_W'(ypos_q) + Y_W'(SCALE * int'(row)) + Y_W'(sub_row);
        visible = (32'(px) < 32'(FB_WIDTH)) && (32'(py) < 32'(FB_HEIGHT))
                  && (!transparent_q || cell_on);
        // Only consumed when visible, so the product is below FB_WIDTH*FB_HEIGHT and fits ADDR_W.
        addr_calc = ADDR_W'(py) * ADDR_W'(FB_WIDTH) + ADDR_W'(px);
        last_pos = (digit == DIGIT_LAST) && (row == 3'd4) && (sub_row == SUB_LAST)
                   && (col == 2'd2) && (sub_col == SUB_LAST);
    end

    // Traversal odometer: sub-column is the fastest-moving position, digit the slowest.
    always_comb begin
        n_digit   = digit;
        n_row     = row;
        n_sub_row = sub_row;
        n_col     = col;
        n_sub_col = sub_col;
        if (sub_col != SUB_LAST) begin
            n_sub_col = sub_col + 1'b1;
        end else begin
            n_sub_col = '0;
            if (col != 2'd2) begin
                n_col = col + 1'b1;
            end else begin
                n_col = 2'd0;
                if (sub_row != SUB_LAST) begin
                    n_sub_row = sub_row + 1'b1;
                end else begin
                    n_sub_row = '0;
                    if (row != 3'd4) begin
                        n_row = row + 1'b1;
                    end else begin
                        n_row   = 3'd0;
                        n_digit = digit + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            value_q       <= '0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            transparent_q <= 1'b0;
            digit         <= '0;
            row           <= '0;
            sub_row       <= '0;
            col           <= '0;
            sub_col       <= '0;
            pix.pix_valid <= 1'b0;
            pix.pix_addr  <= '0;
            pix.pix_data  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        value_q       <= value;
                        xpos_q        <= xpos;
                        ypos_q        <= ypos;
                        transparent_q <= transparent;
                        digit         <= '0;
                        row           <= '0;
                        sub_row       <= '0;
                        col           <= '0;
                        sub_col       <= '0;
                        busy          <= 1'b1;
                        state         <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (visible) begin
                        pix.pix_valid <= 1'b1;
                        pix.pix_addr  <= addr_calc;
                        pix.pix_data  <= cell_on;
                        state         <= S_EMIT;
                    end else if (last_pos) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        digit   <= n_digit;
                        row     <= n_row;
                        sub_row <= n_sub_row;
                        col     <= n_col;
                        sub_col <= n_sub_col;
                    end
                end
                S_EMIT: begin
                    if (pix.pix_ready) begin
                        pix.pix_valid <= 1'b0;
                        if (last_pos) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            digit   <= n_digit;
                            row     <= n_row;
                            sub_row <= n_sub_row;
                            col     <= n_col;
                            sub_col <= n_sub_col;
                            state   <= S_CALC;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hex_glyph_renderer.sv
// tb/tb_hex_glyph_renderer.sv - self-checking bench for hex_glyph_renderer
module tb_hex_glyph_renderer;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    logic       a_start, a_transparent, a_busy, a_done;
    logic [7:0] a_value, a_xpos, a_ypos;
    logic       b_start, b_transparent, b_busy, b_done;
    logic [7:0] b_value, b_xpos, b_ypos;

    hex_glyph_renderer_if #(.ADDR_W(11)) a_if ();
    hex_glyph_renderer_if #(.ADDR_W(11)) b_if ();

    hex_glyph_renderer u_a (
        .clock(clock), .reset_n(reset_n), .start(a_start), .value(a_value),
        .xpos(a_xpos), .ypos(a_ypos), .transparent(a_transparent),
        .pix(a_if), .busy(a_busy), .done(a_done)
    );

    hex_glyph_renderer #(.SCALE(2)) u_b (
        .clock(clock), .reset_n(reset_n), .start(b_start), .value(b_value),
        .xpos(b_xpos), .ypos(b_ypos), .transparent(b_transparent),
        .pix(b_if), .busy(b_busy), .done(b_done)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    int glyph_tab [16] = '{32'h7B6F, 32'h1249, 32'h73E7, 32'h73CF, 32'h5BC9, 32'h79CF,
                           32'h79EF, 32'h7249, 32'h7BEF, 32'h7BC9, 32'h7BED, 32'h49EF,
                           32'h7927, 32'h13EF, 32'h79A7, 32'h79E4};
    int exp40 [10] = '{2, 32, 62, 92, 122, 6, 36, 66, 96, 126};

    // Writes are encoded as addr*2 + data.
    int exp_q[$];
    int got_a[$];
    int got_b[$];

    task automatic build_model(input int scale, input int v, input int xp, input int yp, input int tr);
        exp_q.delete();
        for (int d = 0; d < 2; d++) begin
            int g;
            g = glyph_tab[(v >> (4 * (1 - d))) & 15];
            for (int r = 0; r < 5; r++)
                for (int sr = 0; sr < scale; sr++)
                    for (int c = 0; c < 3; c++)
                        for (int sc = 0; sc < scale; sc++) begin
                            int x, y, on;
                            x  = xp + d * 4 * scale + c * scale + sc;
                            y  = yp + r * scale + sr;
                            on = (g >> (14 - 3 * r - c)) & 1;
                            if (x < 30 && y < 40 && !(tr != 0 && on == 0))
                                exp_q.push_back((y * 30 + x) * 2 + on);
                        end
        end
    endtask

    int done_a = 0, done_at_a = -1, done_b = 0, done_at_b = -1;
    logic held_pending = 1'b0;
    int held_val = 0;

    always @(negedge clock) begin
        if (a_done === 1'b1) begin
            done_a++;
            done_at_a = got_a.size();
            chk("a_busy_in_done", int'(a_busy), 0);
        end
        if (a_if.pix_valid === 1'b1) begin
            if (held_pending)
                chk("a_hold_stable", int'(a_if.pix_addr) * 2 + int'(a_if.pix_data), held_val);
            if (a_if.pix_ready) begin
                got_a.push_back(int'(a_if.pix_addr) * 2 + int'(a_if.pix_data));
                held_pending = 1'b0;
            end else begin
                held_pending = 1'b1;
                held_val = int'(a_if.pix_addr) * 2 + int'(a_if.pix_data);
            end
        end else begin
            held_pending = 1'b0;
        end
        if (b_done === 1'b1) begin
            done_b++;
            done_at_b = got_b.size();
        end
        if (b_if.pix_valid === 1'b1 && b_if.pix_ready === 1'b1)
            got_b.push_back(int'(b_if.pix_addr) * 2 + int'(b_if.pix_data));
    end

    // a_mode: 0 always ready, 1 stall 5 cycles on every third write, 2 random, 3 hold the 7th write.
    int a_mode = 0;
    int stall_left = 0, stalled_for = -1, a_wc = 0;
    logic b_rand = 1'b0;

    always begin
        @(posedge clock);
        #1;
        case (a_mode)
            1: begin
                if (a_if.pix_valid === 1'b1) begin
                    a_wc = got_a.size() + 1;
                    if (a_wc % 3 == 0 && stalled_for != a_wc) begin
                        stall_left  = 5;
                        stalled_for = a_wc;
                    end
                end
                if (stall_left > 0) begin
                    a_if.pix_ready = 1'b0;
                    stall_left--;
                end else begin
                    a_if.pix_ready = 1'b1;
                end
            end
            2: a_if.pix_ready = ($urandom_range(0, 3) != 0);
            3: a_if.pix_ready = (got_a.size() != 6);
            default: a_if.pix_ready = 1'b1;
        endcase
        b_if.pix_ready = b_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    task automatic run_a(input int v, input int xp, input int yp, input int tr,
                         input int mode, input bit mid, input bit lat, input string tag);
        build_model(1, v, xp, yp, tr);
        got_a.delete();
        done_a = 0;
        done_at_a = -1;
        stall_left = 0;
        stalled_for = -1;
        a_mode = mode;
        @(posedge clock);
        #1;
        a_value = 8'(v); a_xpos = 8'(xp); a_ypos = 8'(yp); a_transparent = tr[0];
        a_start = 1'b1;
        @(posedge clock);
        #1;
        a_start = 1'b0;
        if (lat) begin
            @(negedge clock);
            chk({tag, "_busy_n1"}, int'(a_busy), 1);
            chk({tag, "_valid_n1"}, int'(a_if.pix_valid), 0);
            @(negedge clock);
            chk({tag, "_valid_n2"}, int'(a_if.pix_valid), 1);
        end
        for (int c = 0; c < 4000 && done_a == 0; c++) begin
            @(posedge clock);
            #1;
            if (mid) begin
                a_value = 8'($urandom_range(0, 255));
                a_xpos = 8'($urandom_range(0, 255));
                a_ypos = 8'($urandom_range(0, 255));
                a_transparent = 1'($urandom_range(0, 1));
                a_start = a_busy ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        a_start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk({tag, "_done_count"}, done_a, 1);
        chk({tag, "_write_count"}, got_a.size(), exp_q.size());
        chk({tag, "_done_after_last"}, done_at_a, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), got_a[i], exp_q[i]);
    endtask

    task automatic run_b(input int v, input int xp, input int yp, input int tr, input bit rnd, input string tag);
        build_model(2, v, xp, yp, tr);
        got_b.delete();
        done_b = 0;
        done_at_b = -1;
        b_rand = rnd;
        @(posedge clock);
        #1;
        b_value = 8'(v); b_xpos = 8'(xp); b_ypos = 8'(yp); b_transparent = tr[0];
        b_start = 1'b1;
        @(posedge clock);
        #1;
        b_start = 1'b0;
        for (int c = 0; c < 6000 && done_b == 0; c++) @(posedge clock);
        repeat (4) @(posedge clock);
        #1;
        chk({tag, "_done_count"}, done_b, 1);
        chk({tag, "_write_count"}, got_b.size(), exp_q.size());
        chk({tag, "_done_after_last"}, done_at_b, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++)
            chk($sformatf("%s_write%0d", tag, i), got_b[i], exp_q[i]);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        a_start = 1'b0; a_value = '0; a_xpos = '0; a_ypos = '0; a_transparent = 1'b0;
        b_start = 1'b0; b_value = '0; b_xpos = '0; b_ypos = '0; b_transparent = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid", int'(a_if.pix_valid), 0);
        chk("reset_busy", int'(a_busy), 0);
        chk("reset_done", int'(a_done), 0);
        chk("reset_addr", int'(a_if.pix_addr), 0);
        chk("reset_data", int'(a_if.pix_data), 0);
        reset_n = 1'b1;

        run_a(8'h1A, 0, 0, 0, 0, 1'b0, 1'b1, "basic");
        chk("basic_total", got_a.size(), 30);
        chk("basic_w1", got_a[0], 0);
        chk("basic_w2", got_a[1], 2);
        chk("basic_w3", got_a[2], 5);
        chk("basic_digit1_first", got_a[15], 9);

        run_a(8'h1A, 0, 0, 0, 1, 1'b0, 1'b0, "stall");
        chk("stall_total", got_a.size(), 30);

        run_a(8'h88, 28, 0, 0, 0, 1'b0, 1'b0, "clipx");
        chk("clipx_total", got_a.size(), 10);
        for (int i = 0; i < got_a.size(); i++)
            chk($sformatf("clipx_col%0d", i), int'((got_a[i] / 2) % 30 >= 28), 1);

        run_a(8'h11, 0, 0, 1, 0, 1'b0, 1'b0, "transp");
        chk("transp_total", got_a.size(), 10);
        for (int i = 0; i < 10 && i < got_a.size(); i++)
            chk($sformatf("transp_list%0d", i), got_a[i], exp40[i] * 2 + 1);

        run_a(8'h3C, 40, 0, 0, 0, 1'b0, 1'b0, "allclip");
        chk("allclip_total", got_a.size(), 0);

        run_b(8'h80, 0, 0, 0, 1'b0, "scale2");
        chk("scale2_total", got_b.size(), 120);
        chk("scale2_w0", got_b[0], 1);
        chk("scale2_w1", got_b[1], 3);
        chk("scale2_w2", got_b[2], 5);
        chk("scale2_w3", got_b[3], 7);

        // Reset while the 7th write is stalled.
        got_a.delete();
        done_a = 0;
        a_mode = 3;
        @(posedge clock);
        #1;
        a_value = 8'h1A; a_xpos = '0; a_ypos = '0; a_transparent = 1'b0;
        a_start = 1'b1;
        @(posedge clock);
        #1;
        a_start = 1'b0;
        for (int c = 0; c < 500 && !(a_if.pix_valid === 1'b1 && got_a.size() == 6); c++)
            @(negedge clock);
        chk("rst_reached_w7", got_a.size(), 6);
        chk("rst_w7_pending", int'(a_if.pix_valid), 1);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_valid_async", int'(a_if.pix_valid), 0);
        chk("rst_busy_async", int'(a_busy), 0);
        chk("rst_addr_async", int'(a_if.pix_addr), 0);
        chk("rst_data_async", int'(a_if.pix_data), 0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        a_mode = 0;
        repeat (20) @(posedge clock);
        #1;
        chk("rst_no_more_writes", got_a.size(), 6);
        chk("rst_no_done", done_a, 0);
        chk("rst_idle_busy", int'(a_busy), 0);
        run_a(8'h1A, 0, 0, 0, 0, 1'b0, 1'b1, "after_rst");

        for (int k = 0; k < 6; k++)
            run_a($urandom_range(0, 255), $urandom_range(0, 34), $urandom_range(0, 44),
                  $urandom_range(0, 1), 2, 1'b1, 1'b0, $sformatf("rnd%0d", k));
        for (int k = 0; k < 3; k++)
            run_b($urandom_range(0, 255), $urandom_range(0, 34), $urandom_range(0, 44),
                  $urandom_range(0, 1), 1'b1, $sformatf("rndb%0d", k));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
